// File: rtl/text_line_buffer.sv
// Purpose : edits a 40-cell ASCII text line in a shadow buffer from a byte stream and
//           publishes it to the glyph renderer only at frame start, so the line never tears.
// Latency : one PROC cycle per accepted byte (max 1 byte / 2 cycles); form feed adds a 40-cycle wipe.
// Backpressure: in_ready is low outside IDLE (PROC, CLEAR) and while rst_n is low.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_data/in_ready   ASCII byte stream, accepted on in_valid && in_ready
//   frame_start           1-cycle pulse at start of vertical blanking (publish point)
//   character[0:LINE_LEN] published line, cell 0 leftmost, last cell fixed 0x00
//   len, full, overflow   shadow line length, len == LINE_LEN, sticky dropped-byte flag
module text_line_buffer #(
   parameter int LINE_LEN = 40,
   parameter int LEN_W    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic             frame_start,
   output logic [0:7]       character [0:LINE_LEN],
   output logic [LEN_W-1:0] len,
   output logic             full,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROC  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LINE_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state;
   logic [7:0]       byte_q;
   logic [7:0]       shadow [0:LINE_LEN-1];
   logic [0:7]       pub    [0:LINE_LEN-1];
   logic [LEN_W-1:0] clr_idx;
   logic             dirty;

   logic             is_digit, is_upper, is_lower, is_space, printable;
   logic [7:0]       store_val;
   logic             do_ins, do_drop, do_bs, do_ff, change, commit;
   logic [LEN_W-1:0] len_m1;

   always_comb begin
      is_digit  = (byte_q >= 8'h30) && (byte_q <= 8'h39);
      is_upper  = (byte_q >= 8'h41) && (byte_q <= 8'h5A);
      is_lower  = (byte_q >= 8'h61) && (byte_q <= 8'h7A);
      is_space  = (byte_q == 8'h20);
      printable = is_digit || is_upper || is_lower || is_space;

      // Renderer draws only digits/capitals; space is stored as the blank code 0x00.
      store_val = byte_q;
      if (is_lower) store_val = byte_q - 8'h20;
      if (is_space) store_val = 8'h00;

      do_ins  = (state == PROC) && printable && (len != LEN_MAX);
      do_drop = (state == PROC) && printable && (len == LEN_MAX);
      do_bs   = (state == PROC) && (byte_q == 8'h08) && (len != '0);
      do_ff   = (state == PROC) && (byte_q == 8'h0C);
      change  = do_ins || do_bs || do_ff;

      // Commit is held off during the wipe so a half-cleared line is never shown.
      commit  = frame_start && dirty && (state != CLEAR);
      len_m1  = len - LEN_ONE;
   end

   assign in_ready = (state == IDLE) && rst_n;
   assign full     = (len == LEN_MAX);

   always_comb begin
      for (int i = 0; i < LINE_LEN; i++) character[i] = pub[i];
      character[LINE_LEN] = 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         byte_q   <= 8'h00;
         len      <= '0;
         overflow <= 1'b0;
         dirty    <= 1'b0;
         clr_idx  <= '0;
         for (int i = 0; i < LINE_LEN; i++) begin
            shadow[i] <= 8'h00;
            pub[i]    <= 8'h00;
         end
      end else begin
         // Commit samples the shadow before any same-edge edit; such an edit keeps
         // dirty set so it publishes at the following frame.
         if (commit) begin
            for (int i = 0; i < LINE_LEN; i++) pub[i] <= shadow[i];
         end
         dirty <= (commit ? 1'b0 : dirty) | change;

         case (state)
            IDLE: begin
               if (in_valid) begin
                  byte_q <= in_data;
                  state  <= PROC;
               end
            end
            PROC: begin
               state <= IDLE;
               if (do_ins) begin
                  shadow[len] <= store_val;
                  len         <= len + LEN_ONE;
               end
               if (do_drop) overflow <= 1'b1;
               if (do_bs) begin
                  shadow[len_m1] <= 8'h00;
                  len            <= len_m1;
               end
               if (do_ff) begin
                  len      <= '0;
                  overflow <= 1'b0;
                  clr_idx  <= '0;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               shadow[clr_idx] <= 8'h00;
               if (clr_idx == LEN_MAX - LEN_ONE) state <= IDLE;
               else clr_idx <= clr_idx + LEN_ONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_line_buffer.sv
// Purpose : directed self-checking bench for text_line_buffer.
// Latency : drives inputs 1ns after the rising edge and samples outputs at the same point.
// Backpressure: every wait on in_ready is bounded; an expired wait is reported as a failure.
module tb_text_line_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       frame_start;
   logic [0:7] character [0:40];
   logic [5:0] len;
   logic       full;
   logic       overflow;

   logic [7:0] exp_line [0:40];
   int         n_chk = 0;
   int         n_err = 0;

   text_line_buffer #(.LINE_LEN(40), .LEN_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .frame_start (frame_start),
      .character   (character),
      .len         (len),
      .full        (full),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_clear();
      for (int i = 0; i <= 40; i++) exp_line[i] = 8'h00;
   endtask

   task automatic check_line(input string tag);
      for (int i = 0; i <= 40; i++)
         chk($sformatf("%s[%0d]", tag, i), {24'h0, character[i]}, {24'h0, exp_line[i]});
   endtask

   // Hands over one byte and returns 1ns after the edge that ends PROC.
   // fs_in_proc raises frame_start on the PROC cycle so it coincides with the write.
   task automatic send(input logic [7:0] b, input bit fs_in_proc);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      chk("rdy_wait", {31'h0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      if (fs_in_proc) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; frame_start = 1'b0;
      tick(); tick();
      // Reset state
      exp_clear();
      chk("rst_ready", {31'h0, in_ready}, 32'd0);
      chk("rst_len",   {26'h0, len}, 32'd0);
      chk("rst_full",  {31'h0, full}, 32'd0);
      chk("rst_ovf",   {31'h0, overflow}, 32'd0);
      check_line("rst_line");
      rst_n = 1'b1;
      tick();
      chk("idle_ready", {31'h0, in_ready}, 32'd1);

      // Test 1: "A","1","z" -> 41 31 5A after frame_start only
      send(8'h41, 0); send(8'h31, 0); send(8'h7A, 0);
      chk("t1_len", {26'h0, len}, 32'd3);
      check_line("t1_prepub");
      frame();
      exp_line[0] = 8'h41; exp_line[1] = 8'h31; exp_line[2] = 8'h5A;
      check_line("t1_pub");

      // Test 2: "AB" held back until next frame_start
      send(8'h41, 0); send(8'h42, 0);
      tick(); tick(); tick();
      chk("t2_len", {26'h0, len}, 32'd5);
      check_line("t2_hold");
      frame();
      exp_line[3] = 8'h41; exp_line[4] = 8'h42;
      check_line("t2_pub");

      // Test 3: fill to 40, overflow on the 41st, backspace
      for (int i = 0; i < 35; i++) send(8'h58, 0);
      chk("t3_len40", {26'h0, len}, 32'd40);
      chk("t3_full",  {31'h0, full}, 32'd1);
      chk("t3_ovf0",  {31'h0, overflow}, 32'd0);
      send(8'h58, 0);
      chk("t3_drop_len", {26'h0, len}, 32'd40);
      chk("t3_ovf1",     {31'h0, overflow}, 32'd1);
      send(8'h08, 0);
      chk("t3_bs_len",  {26'h0, len}, 32'd39);
      chk("t3_bs_full", {31'h0, full}, 32'd0);
      chk("t3_ovf_sticky", {31'h0, overflow}, 32'd1);
      frame();
      for (int i = 5; i < 39; i++) exp_line[i] = 8'h58;
      check_line("t3_pub");

      // Test 4: form feed wipe, frame_start mid-CLEAR must not publish
      send(8'h0C, 0);
      chk("t4_clr_ready", {31'h0, in_ready}, 32'd0);
      chk("t4_clr_len",   {26'h0, len}, 32'd0);
      chk("t4_clr_ovf",   {31'h0, overflow}, 32'd0);
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         frame_start = (cnt == 5);
         tick();
         cnt++;
      end
      frame_start = 1'b0;
      chk("t4_clr_cycles", cnt, 32'd40);
      check_line("t4_nopub");
      send(8'h08, 0);
      chk("t4_bs0_len", {26'h0, len}, 32'd0);
      frame();
      exp_clear();
      check_line("t4_pub_blank");

      // Test 5: write coinciding with frame_start publishes the pre-write line
      send(8'h35, 0);
      send(8'h37, 1);
      exp_line[0] = 8'h35;
      check_line("t5_old");
      frame();
      exp_line[1] = 8'h37;
      check_line("t5_new");
      // space -> blank cell, lowercase folded, other codes ignored
      send(8'h20, 0); send(8'h61, 0); send(8'h21, 0);
      chk("t5_len", {26'h0, len}, 32'd4);
      frame();
      exp_line[3] = 8'h41;
      check_line("t5_misc");

      // Test 6: reset mid-CLEAR with in_valid held
      send(8'h0C, 0);
      tick(); tick(); tick();
      in_valid = 1'b1; in_data = 8'h51;
      rst_n = 1'b0;
      #1;
      chk("t6_rdy_in_rst", {31'h0, in_ready}, 32'd0);
      tick();
      chk("t6_rdy", {31'h0, in_ready}, 32'd0);
      chk("t6_len", {26'h0, len}, 32'd0);
      chk("t6_ovf", {31'h0, overflow}, 32'd0);
      exp_clear();
      check_line("t6_line");
      rst_n = 1'b1;
      #1;
      chk("t6_rdy_rel", {31'h0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("t6_accept_len", {26'h0, len}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
